// File: rtl/dma_burst_scheduler.sv
// dma_burst_scheduler
//   Takes one granted DMA channel transfer and cuts it into word bursts for the
//   DMA engine. A burst is at most MAX_BEATS beats of 4 bytes. No burst crosses
//   a 4KB page on either the source or the destination side. Each burst is
//   offered with a valid/ready handshake. The next burst is not computed until
//   the engine reports completion of the current one.
//
// Ports
//   clk, rst_n           clock; asynchronous active-low reset
//   start, start_ch,     one-cycle transfer request with channel, source and
//   start_src/dst/len    destination byte addresses and byte length
//   abort                level request for early termination (sticky while busy)
//   busy                 transfer in progress
//   cmd_valid/ready      burst command handshake
//   cmd_src/dst/beats/ch burst command payload
//   burst_done/err       engine completion pulse and its error qualifier
//   xfer_done/err/ch     transfer completion pulse, status and channel
//   bytes_left           bytes not yet handed to the engine as commands
module dma_burst_scheduler #(
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 16,
  parameter int MAX_BEATS = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [1:0]                     start_ch,
  input  logic [ADDR_W-1:0]              start_src,
  input  logic [ADDR_W-1:0]              start_dst,
  input  logic [LEN_W-1:0]               start_len,
  input  logic                           abort,
  output logic                           busy,
  output logic                           cmd_valid,
  input  logic                           cmd_ready,
  output logic [ADDR_W-1:0]              cmd_src,
  output logic [ADDR_W-1:0]              cmd_dst,
  output logic [$clog2(MAX_BEATS):0]     cmd_beats,
  output logic [1:0]                     cmd_ch,
  input  logic                           burst_done,
  input  logic                           burst_err,
  output logic                           xfer_done,
  output logic                           xfer_err,
  output logic [1:0]                     xfer_ch,
  output logic [LEN_W-1:0]               bytes_left
);

  localparam int BEAT_W = $clog2(MAX_BEATS) + 1;
  // Wide enough for both the remaining-word count and a full page in words.
  localparam int CALC_W = (LEN_W > 13) ? LEN_W : 13;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   src_r;
  logic [ADDR_W-1:0]   dst_r;
  logic [1:0]          ch_r;
  logic                abort_r;

  logic [CALC_W-1:0]   rem_words_s;
  logic [CALC_W-1:0]   src_room_s;
  logic [CALC_W-1:0]   dst_room_s;
  logic [CALC_W-1:0]   max_words_s;
  logic [CALC_W-1:0]   min_words_s;
  logic [BEAT_W-1:0]   beats_s;
  logic [ADDR_W-1:0]   step_addr_s;
  logic [LEN_W-1:0]    step_len_s;
  logic                misaligned_s;

  function automatic logic [CALC_W-1:0] min2(input logic [CALC_W-1:0] a,
                                             input logic [CALC_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Burst sizing: smallest of the beat cap, remaining words and page room on both sides.
  always_comb begin
    rem_words_s  = CALC_W'(bytes_left >> 2);
    src_room_s   = CALC_W'((13'd4096 - {1'b0, src_r[11:0]}) >> 2);
    dst_room_s   = CALC_W'((13'd4096 - {1'b0, dst_r[11:0]}) >> 2);
    max_words_s  = CALC_W'(MAX_BEATS);
    min_words_s  = min2(min2(max_words_s, rem_words_s), min2(src_room_s, dst_room_s));
    beats_s      = BEAT_W'(min_words_s);
    step_addr_s  = ADDR_W'({cmd_beats, 2'b00});
    step_len_s   = LEN_W'({cmd_beats, 2'b00});
    misaligned_s = (|start_src[1:0]) | (|start_dst[1:0]) | (|start_len[1:0]);
  end

  // Transfer sequencer: state, working addresses and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      src_r      <= '0;
      dst_r      <= '0;
      ch_r       <= 2'd0;
      abort_r    <= 1'b0;
      busy       <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_src    <= '0;
      cmd_dst    <= '0;
      cmd_beats  <= '0;
      cmd_ch     <= 2'd0;
      xfer_done  <= 1'b0;
      xfer_err   <= 1'b0;
      xfer_ch    <= 2'd0;
      bytes_left <= '0;
    end else begin
      xfer_done <= 1'b0;
      // Abort is sticky for the rest of the transfer; DONE clears it below.
      if ((state_r != IDLE) && abort) begin
        abort_r <= 1'b1;
      end else begin
        abort_r <= abort_r;
      end

      case (state_r)
        IDLE: begin
          if (start) begin
            ch_r       <= start_ch;
            src_r      <= start_src;
            dst_r      <= start_dst;
            bytes_left <= start_len;
            busy       <= 1'b1;
            if (misaligned_s) begin
              state_r   <= DONE;
              xfer_done <= 1'b1;
              xfer_err  <= 1'b1;
              xfer_ch   <= start_ch;
            end else if (start_len == '0) begin
              state_r   <= DONE;
              xfer_done <= 1'b1;
              xfer_err  <= 1'b0;
              xfer_ch   <= start_ch;
            end else begin
              state_r <= CALC;
            end
          end
        end

        CALC: begin
          if (abort_r) begin
            state_r   <= DONE;
            xfer_done <= 1'b1;
            xfer_err  <= 1'b1;
            xfer_ch   <= ch_r;
          end else begin
            cmd_src   <= src_r;
            cmd_dst   <= dst_r;
            cmd_beats <= beats_s;
            cmd_ch    <= ch_r;
            cmd_valid <= 1'b1;
            state_r   <= ISSUE;
          end
        end

        // Valid stays up until accepted, abort or not.
        ISSUE: begin
          if (cmd_ready) begin
            cmd_valid  <= 1'b0;
            src_r      <= src_r + step_addr_s;
            dst_r      <= dst_r + step_addr_s;
            bytes_left <= bytes_left - step_len_s;
            state_r    <= WAIT;
          end
        end

        WAIT: begin
          if (burst_done) begin
            if (burst_err || abort_r) begin
              state_r   <= DONE;
              xfer_done <= 1'b1;
              xfer_err  <= 1'b1;
              xfer_ch   <= ch_r;
            end else if (bytes_left == '0) begin
              state_r   <= DONE;
              xfer_done <= 1'b1;
              xfer_err  <= 1'b0;
              xfer_ch   <= ch_r;
            end else begin
              state_r <= CALC;
            end
          end
        end

        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          abort_r <= 1'b0;
        end

        default: begin
          state_r   <= IDLE;
          busy      <= 1'b0;
          cmd_valid <= 1'b0;
          abort_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule
